// File: rtl/msrv32_dbus_if_pkg.sv
// Shared definitions for the msrv32 AHB-Lite data-bus master.
package msrv32_dbus_if_pkg;

    // AHB transfer-type codes used by this master.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Access-size encodings as presented by the pipeline.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Bus master state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

    // The reserved size code 11 behaves as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_WORD : size;
    endfunction

endpackage

// File: rtl/msrv32_dbus_if_if.sv
// AHB-Lite data-bus signal bundle between the msrv32 data master and a slave.
interface msrv32_dbus_if_if;
    logic [31:0] haddr_out;
    logic [1:0]  htrans_out;
    logic        hwrite_out;
    logic [2:0]  hsize_out;
    logic [31:0] hwdata_out;
    logic [3:0]  hwstrb_out;
    logic        hready_in;
    logic        hresp_in;
    logic [31:0] hrdata_in;

    modport master (
        output haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out, hwstrb_out,
        input  hready_in, hresp_in, hrdata_in
    );

    modport slave (
        input  haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out, hwstrb_out,
        output hready_in, hresp_in, hrdata_in
    );
endinterface

// File: rtl/msrv32_store_align.sv
// Store lane replication, byte-strobe generation and alignment check.
module msrv32_store_align
    import msrv32_dbus_if_pkg::*;
(
    input  logic [1:0]  addr_lo_in,
    input  logic [1:0]  size_in,
    input  logic [31:0] data_in,
    output logic [31:0] wdata_out,
    output logic [3:0]  wstrb_out,
    output logic        misaligned_out
);

    // Replicate store data onto every lane it could occupy and pick the active strobes.
    always_comb begin
        wdata_out      = 32'h0000_0000;
        wstrb_out      = 4'b0000;
        misaligned_out = 1'b0;
        case (size_in)
            SZ_BYTE: begin
                wdata_out      = {4{data_in[7:0]}};
                wstrb_out      = 4'b0001 << addr_lo_in;
                misaligned_out = 1'b0;
            end
            SZ_HALF: begin
                wdata_out      = {2{data_in[15:0]}};
                wstrb_out      = 4'b0011 << {addr_lo_in[1], 1'b0};
                misaligned_out = addr_lo_in[0];
            end
            default: begin
                // Word, including the reserved code 11.
                wdata_out      = data_in;
                wstrb_out      = 4'b1111;
                misaligned_out = (addr_lo_in != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/msrv32_dbus_if.sv
// AHB-Lite data-bus master: one load/store at a time, registered results for the load unit.
module msrv32_dbus_if
    import msrv32_dbus_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    msrv32_dbus_if_if.master   ahb,
    input  logic               mem_req_in,
    input  logic               mem_we_in,
    input  logic [1:0]         mem_size_in,
    input  logic               mem_unsigned_in,
    input  logic [31:0]        iadder_in,
    input  logic [31:0]        rs2_in,
    output logic               stall_out,
    output logic               misaligned_out,
    output logic               done_out,
    output logic [31:0]        data_out,
    output logic               ahb_resp_out,
    output logic [1:0]         iadder_1_to_0_out,
    output logic [1:0]         load_size_out,
    output logic               load_unsigned_out
);

    localparam bit             WDOG_EN  = (TIMEOUT_CYCLES != 0);
    // Abort fires on the edge where the wait count would reach TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(WDOG_EN ? (TIMEOUT_CYCLES - 1) : 0);

    state_e            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       haddr_r;
    logic [1:0]        htrans_r;
    logic              hwrite_r;
    logic [2:0]        hsize_r;
    logic [31:0]       hwdata_r;
    logic [3:0]        hwstrb_r;
    logic [31:0]       lane_data_r;
    logic [3:0]        lane_strb_r;
    logic              stall_r;
    logic              misaligned_r;
    logic              done_r;
    logic [31:0]       data_r;
    logic              resp_r;
    logic [1:0]        addr_lo_r;
    logic [1:0]        load_size_r;
    logic              load_unsigned_r;

    logic [1:0]        size_norm_s;
    logic [31:0]       lane_data_s;
    logic [3:0]        lane_strb_s;
    logic              misaligned_s;

    assign size_norm_s = norm_size(mem_size_in);

    msrv32_store_align u_align (
        .addr_lo_in     (iadder_in[1:0]),
        .size_in        (size_norm_s),
        .data_in        (rs2_in),
        .wdata_out      (lane_data_s),
        .wstrb_out      (lane_strb_s),
        .misaligned_out (misaligned_s)
    );

    // Transfer sequencing: address phase, data phase, error completion and watchdog abort.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r         <= ST_IDLE;
            cnt_r           <= '0;
            haddr_r         <= 32'h0000_0000;
            htrans_r        <= HTRANS_IDLE;
            hwrite_r        <= 1'b0;
            hsize_r         <= 3'b000;
            hwdata_r        <= 32'h0000_0000;
            hwstrb_r        <= 4'b0000;
            lane_data_r     <= 32'h0000_0000;
            lane_strb_r     <= 4'b0000;
            stall_r         <= 1'b0;
            misaligned_r    <= 1'b0;
            done_r          <= 1'b0;
            data_r          <= 32'h0000_0000;
            resp_r          <= 1'b0;
            addr_lo_r       <= 2'b00;
            load_size_r     <= 2'b00;
            load_unsigned_r <= 1'b0;
        end else begin
            done_r       <= 1'b0;
            misaligned_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Stall drops after the done cycle unless a new request is taken.
                    stall_r <= 1'b0;
                    if (mem_req_in) begin
                        if (misaligned_s) begin
                            misaligned_r <= 1'b1;
                        end else begin
                            haddr_r         <= iadder_in;
                            htrans_r        <= HTRANS_NONSEQ;
                            hwrite_r        <= mem_we_in;
                            hsize_r         <= {1'b0, size_norm_s};
                            lane_data_r     <= lane_data_s;
                            lane_strb_r     <= lane_strb_s;
                            addr_lo_r       <= iadder_in[1:0];
                            load_size_r     <= size_norm_s;
                            load_unsigned_r <= mem_unsigned_in;
                            stall_r         <= 1'b1;
                            state_r         <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (ahb.hready_in) begin
                        htrans_r <= HTRANS_IDLE;
                        hwdata_r <= hwrite_r ? lane_data_r : 32'h0000_0000;
                        hwstrb_r <= hwrite_r ? lane_strb_r : 4'b0000;
                        cnt_r    <= '0;
                        state_r  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (ahb.hresp_in) begin
                        if (ahb.hready_in) begin
                            resp_r   <= 1'b1;
                            done_r   <= 1'b1;
                            hwdata_r <= 32'h0000_0000;
                            hwstrb_r <= 4'b0000;
                            state_r  <= ST_IDLE;
                        end else begin
                            state_r  <= ST_ERR;
                        end
                    end else if (ahb.hready_in) begin
                        if (!hwrite_r) begin
                            data_r <= ahb.hrdata_in;
                        end
                        resp_r   <= 1'b0;
                        done_r   <= 1'b1;
                        hwdata_r <= 32'h0000_0000;
                        hwstrb_r <= 4'b0000;
                        state_r  <= ST_IDLE;
                    end else if (WDOG_EN && (cnt_r == TMO_LAST)) begin
                        resp_r   <= 1'b1;
                        done_r   <= 1'b1;
                        hwdata_r <= 32'h0000_0000;
                        hwstrb_r <= 4'b0000;
                        state_r  <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_ERR: begin
                    // Second ERROR cycle: read data is left untouched.
                    if (ahb.hready_in) begin
                        resp_r   <= 1'b1;
                        done_r   <= 1'b1;
                        hwdata_r <= 32'h0000_0000;
                        hwstrb_r <= 4'b0000;
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    htrans_r <= HTRANS_IDLE;
                    hwstrb_r <= 4'b0000;
                    stall_r  <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign ahb.haddr_out   = haddr_r;
    assign ahb.htrans_out  = htrans_r;
    assign ahb.hwrite_out  = hwrite_r;
    assign ahb.hsize_out   = hsize_r;
    assign ahb.hwdata_out  = hwdata_r;
    assign ahb.hwstrb_out  = hwstrb_r;

    assign stall_out         = stall_r;
    assign misaligned_out    = misaligned_r;
    assign done_out          = done_r;
    assign data_out          = data_r;
    assign ahb_resp_out      = resp_r;
    assign iadder_1_to_0_out = addr_lo_r;
    assign load_size_out     = load_size_r;
    assign load_unsigned_out = load_unsigned_r;

endmodule

// File: tb/tb_msrv32_dbus_if.sv
// Directed bench for msrv32_dbus_if; dut0 has the watchdog off, dut4 uses a 4-cycle limit.
module tb_msrv32_dbus_if;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        mem_unsigned = 1'b0;
    logic [31:0] iadder = 32'h0;
    logic [31:0] rs2 = 32'h0;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;
    logic [31:0] hrdata = 32'h0;

    logic        stall0, misal0, done0, resp0, lun0;
    logic [31:0] data0;
    logic [1:0]  ia0, lsz0;
    logic        stall4, misal4, done4, resp4, lun4;
    logic [31:0] data4;
    logic [1:0]  ia4, lsz4;

    int passed = 0;
    int total = 0;
    int done_cnt = 0;
    int stall_cnt = 0;
    int mis_cnt = 0;
    int snap_done, snap_stall, snap_mis;

    msrv32_dbus_if_if bus0 ();
    msrv32_dbus_if_if bus4 ();

    assign bus0.hready_in = hready;
    assign bus0.hresp_in  = hresp;
    assign bus0.hrdata_in = hrdata;
    assign bus4.hready_in = hready;
    assign bus4.hresp_in  = hresp;
    assign bus4.hrdata_in = hrdata;

    msrv32_dbus_if #(.TIMEOUT_CYCLES(0), .CNT_W(8)) dut0 (
        .clk_in(clk_in), .rst_in(rst_in), .ahb(bus0),
        .mem_req_in(mem_req), .mem_we_in(mem_we), .mem_size_in(mem_size),
        .mem_unsigned_in(mem_unsigned), .iadder_in(iadder), .rs2_in(rs2),
        .stall_out(stall0), .misaligned_out(misal0), .done_out(done0),
        .data_out(data0), .ahb_resp_out(resp0), .iadder_1_to_0_out(ia0),
        .load_size_out(lsz0), .load_unsigned_out(lun0)
    );

    msrv32_dbus_if #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut4 (
        .clk_in(clk_in), .rst_in(rst_in), .ahb(bus4),
        .mem_req_in(mem_req), .mem_we_in(mem_we), .mem_size_in(mem_size),
        .mem_unsigned_in(mem_unsigned), .iadder_in(iadder), .rs2_in(rs2),
        .stall_out(stall4), .misaligned_out(misal4), .done_out(done4),
        .data_out(data4), .ahb_resp_out(resp4), .iadder_1_to_0_out(ia4),
        .load_size_out(lsz4), .load_unsigned_out(lun4)
    );

    // 100 MHz-style free-running clock.
    always #5 clk_in = ~clk_in;

    // Event counters for dut0, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (done0 === 1'b1)  done_cnt  <= done_cnt + 1;
        if (stall0 === 1'b1) stall_cnt <= stall_cnt + 1;
        if (misal0 === 1'b1) mis_cnt   <= mis_cnt + 1;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic request(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
        mem_req      = 1'b1;
        mem_we       = we;
        mem_size     = sz;
        mem_unsigned = uns;
        iadder       = addr;
        rs2          = wd;
    endtask

    initial begin
        // Reset
        tick(); tick();
        rst_in = 1'b0;
        tick();
        chk("rst_htrans", {30'd0, bus0.htrans_out}, 32'h0);
        chk("rst_stall",  {31'd0, stall0}, 32'h0);
        chk("rst_done",   {31'd0, done0}, 32'h0);
        chk("rst_data",   data0, 32'h0);
        chk("rst_strb",   {28'd0, bus0.hwstrb_out}, 32'h0);
        chk("rst_resp",   {31'd0, resp0}, 32'h0);
        chk("rst_haddr",  bus0.haddr_out, 32'h0);

        // Load word 0x1000, zero wait states; request sampled at cycle N.
        request(1'b0, 2'b10, 1'b1, 32'h0000_1000, 32'h0);
        hrdata = 32'hDEAD_BEEF;
        tick();                                  // N+1 address phase
        mem_req = 1'b0;
        chk("lw_htrans_a", {30'd0, bus0.htrans_out}, 32'h2);
        chk("lw_haddr",    bus0.haddr_out, 32'h0000_1000);
        chk("lw_hsize",    {29'd0, bus0.hsize_out}, 32'h2);
        chk("lw_hwrite",   {31'd0, bus0.hwrite_out}, 32'h0);
        chk("lw_stall_a",  {31'd0, stall0}, 32'h1);
        tick();                                  // N+2 data phase
        chk("lw_htrans_d", {30'd0, bus0.htrans_out}, 32'h0);
        chk("lw_strb_d",   {28'd0, bus0.hwstrb_out}, 32'h0);
        chk("lw_done_d",   {31'd0, done0}, 32'h0);
        tick();                                  // N+3 done
        chk("lw_done",     {31'd0, done0}, 32'h1);
        chk("lw_data",     data0, 32'hDEAD_BEEF);
        chk("lw_resp",     {31'd0, resp0}, 32'h0);
        chk("lw_stall_n",  {31'd0, stall0}, 32'h1);
        chk("lw_lsize",    {30'd0, lsz0}, 32'h2);
        chk("lw_luns",     {31'd0, lun0}, 32'h1);
        tick();
        chk("lw_done_off", {31'd0, done0}, 32'h0);
        chk("lw_stall_off",{31'd0, stall0}, 32'h0);

        // Store byte 0xA5 at 0x2003 with 2 wait states.
        snap_stall = stall_cnt;
        request(1'b1, 2'b00, 1'b0, 32'h0000_2003, 32'h1234_56A5);
        tick();                                  // address phase
        mem_req = 1'b0;
        chk("sb_hwrite",  {31'd0, bus0.hwrite_out}, 32'h1);
        chk("sb_hsize",   {29'd0, bus0.hsize_out}, 32'h0);
        chk("sb_ia",      {30'd0, ia0}, 32'h3);
        tick();                                  // data phase, first cycle
        chk("sb_hwdata",  bus0.hwdata_out, 32'hA5A5_A5A5);
        chk("sb_hwstrb",  {28'd0, bus0.hwstrb_out}, 32'h8);
        hready = 1'b0;
        tick();
        tick();
        hready = 1'b1;
        chk("sb_strb_hold", {28'd0, bus0.hwstrb_out}, 32'h8);
        tick();                                  // done
        chk("sb_done",    {31'd0, done0}, 32'h1);
        chk("sb_data_keep", data0, 32'hDEAD_BEEF);
        chk("sb_strb_clr", {28'd0, bus0.hwstrb_out}, 32'h0);
        tick();
        chk("sb_stall_cycles", stall_cnt - snap_stall, 32'd5);

        // Store half 0xBEEF at 0x7002: upper-half strobes.
        request(1'b1, 2'b01, 1'b0, 32'h0000_7002, 32'h0000_BEEF);
        tick();
        mem_req = 1'b0;
        tick();
        chk("sh_hwdata",  bus0.hwdata_out, 32'hBEEF_BEEF);
        chk("sh_hwstrb",  {28'd0, bus0.hwstrb_out}, 32'hC);
        tick();
        chk("sh_done",    {31'd0, done0}, 32'h1);
        tick();

        // Misaligned half load at 0x3001.
        snap_done = done_cnt;
        snap_mis  = mis_cnt;
        request(1'b0, 2'b01, 1'b0, 32'h0000_3001, 32'h0);
        tick();
        mem_req = 1'b0;
        chk("mis_pulse",  {31'd0, misal0}, 32'h1);
        chk("mis_htrans", {30'd0, bus0.htrans_out}, 32'h0);
        chk("mis_stall",  {31'd0, stall0}, 32'h0);
        tick();
        chk("mis_off",    {31'd0, misal0}, 32'h0);
        chk("mis_ia_keep",{30'd0, ia0}, 32'h2);
        tick(); tick();
        chk("mis_no_done", done_cnt - snap_done, 32'd0);
        chk("mis_once",   mis_cnt - snap_mis, 32'd1);

        // Two-cycle ERROR response on a load.
        snap_done = done_cnt;
        hrdata = 32'h5555_AAAA;
        request(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0);
        tick();
        mem_req = 1'b0;
        tick();                                  // data phase
        hresp  = 1'b1;
        hready = 1'b0;
        tick();                                  // first ERROR cycle taken
        hready = 1'b1;
        chk("err_done_early", {31'd0, done0}, 32'h0);
        tick();
        hresp = 1'b0;
        chk("err_done",  {31'd0, done0}, 32'h1);
        chk("err_resp",  {31'd0, resp0}, 32'h1);
        chk("err_data",  data0, 32'hDEAD_BEEF);
        tick(); tick();
        chk("err_once",  done_cnt - snap_done, 32'd1);

        // Watchdog: dut4 aborts after 4 data-phase cycles, dut0 keeps waiting.
        request(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0);
        tick();
        mem_req = 1'b0;
        tick();                                  // first data-phase cycle
        hready = 1'b0;
        hrdata = 32'hCAFE_F00D;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("wd_wait%0d", i), {31'd0, done4}, 32'h0);
        end
        tick();
        chk("wd_done4",  {31'd0, done4}, 32'h1);
        chk("wd_resp4",  {31'd0, resp4}, 32'h1);
        chk("wd_data4",  data4, 32'hDEAD_BEEF);
        chk("wd_done0",  {31'd0, done0}, 32'h0);
        chk("wd_stall0", {31'd0, stall0}, 32'h1);
        tick();
        chk("wd_stall4_off", {31'd0, stall4}, 32'h0);
        tick(); tick();
        chk("wd_done0_wait", {31'd0, done0}, 32'h0);
        hready = 1'b1;
        tick();
        chk("wd_done0_late", {31'd0, done0}, 32'h1);
        chk("wd_data0",  data0, 32'hCAFE_F00D);
        chk("wd_resp0",  {31'd0, resp0}, 32'h0);
        tick();

        // Reset during the data phase of a word store (reserved size code 11).
        snap_done = done_cnt;
        request(1'b1, 2'b11, 1'b0, 32'h0000_6000, 32'h1122_3344);
        tick();
        mem_req = 1'b0;
        chk("rs_hsize",  {29'd0, bus0.hsize_out}, 32'h2);
        tick();
        chk("rs_hwdata", bus0.hwdata_out, 32'h1122_3344);
        chk("rs_hwstrb", {28'd0, bus0.hwstrb_out}, 32'hF);
        hready = 1'b0;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        hready = 1'b1;
        chk("rs_stall",  {31'd0, stall0}, 32'h0);
        chk("rs_htrans", {30'd0, bus0.htrans_out}, 32'h0);
        chk("rs_strb",   {28'd0, bus0.hwstrb_out}, 32'h0);
        chk("rs_data",   data0, 32'h0);
        tick(); tick();
        chk("rs_no_done", done_cnt - snap_done, 32'd0);
        chk("rs_stall_idle", {31'd0, stall0}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed %0d checks", total);
        $fatal(1);
    end

endmodule

// File: doc/msrv32_dbus_if.md
Name: msrv32_dbus_if

Overview:
AHB-Lite data-bus master for loads and stores. It sits between the execute stage and the load unit.
- Accepts one load/store request at a time from the pipeline.
- Generates the AHB address and data phases, including byte-lane alignment and strobes for stores.
- Registers the read data, the response and the access attributes, then hands them to the load unit.
- Stalls the pipeline while a transfer is outstanding.

Parameters:
TIMEOUT_CYCLES, 0, maximum wait-state cycles in the data phase before a forced error abort; 0 disables the watchdog.
CNT_W, 8, width of the watchdog counter; TIMEOUT_CYCLES must be less than 2**CNT_W.

Ports:
clk_in  input  1  clock; all logic is on the rising edge.
rst_in  input  1  reset, synchronous, active-high.
mem_req_in  input  1  request strobe, one cycle, sampled only in IDLE.
mem_we_in  input  1  1 = store, 0 = load.
mem_size_in  input  2  00 byte, 01 half, 10 word; 11 is treated as word.
mem_unsigned_in  input  1  load zero-extension flag, carried through to the load unit.
iadder_in  input  32  effective address.
rs2_in  input  32  store data, LSB-aligned.
hready_in  input  1  AHB HREADY.
hresp_in  input  1  AHB HRESP (1 = ERROR).
hrdata_in  input  32  AHB HRDATA.
haddr_out  output  32  AHB HADDR.
htrans_out  output  2  AHB HTRANS: IDLE = 00, NONSEQ = 10.
hwrite_out  output  1  AHB HWRITE.
hsize_out  output  3  AHB HSIZE: {1'b0, size}.
hwdata_out  output  32  AHB HWDATA, lane-replicated store data.
hwstrb_out  output  4  byte strobes.
stall_out  output  1  pipeline stall while the block is busy.
misaligned_out  output  1  one-cycle pulse on a misaligned request.
done_out  output  1  one-cycle pulse when a transfer completes.
data_out  output  32  registered read data, feeds the load unit's data_in.
ahb_resp_out  output  1  registered error flag, feeds the load unit's ahb_resp_in.
iadder_1_to_0_out  output  2  registered address[1:0], feeds the load unit.
load_size_out  output  2  registered size, feeds the load unit.
load_unsigned_out  output  1  registered unsigned flag, feeds the load unit.

Behaviour:
- Reset values: all outputs 0 (htrans_out = IDLE, strobes = 0, ahb_resp_out = 0, data_out = 0); state = IDLE; watchdog counter = 0. Reset mid-transfer returns to IDLE immediately and drops the outstanding transfer; no done_out is produced for it.
- States: IDLE, ADDR, DATA, ERR.
- IDLE:
  - On mem_req_in with an aligned address: latch address, we, size, unsigned and lane-replicated data; drive the AHB address phase the next cycle; go to ADDR.
  - Misaligned means half with addr[0] = 1, or word with addr[1:0] != 0. Such a request starts no bus transfer: pulse misaligned_out for one cycle and stay in IDLE.
- ADDR: htrans_out = NONSEQ, address controls valid. Hold until hready_in = 1, then go to DATA. htrans_out returns to IDLE in the same edge.
- DATA:
  - hwdata_out/hwstrb_out are driven for stores; strobes are 0 for loads.
  - While hready_in = 0 and hresp_in = 0: wait and increment the counter.
  - hready_in = 1 and hresp_in = 0: capture hrdata_in into data_out (loads only), clear ahb_resp_out, pulse done_out, go to IDLE.
  - hresp_in = 1 (first ERROR cycle, hready_in = 0): go to ERR.
  - If hresp_in = 1 and hready_in = 1 arrive in the same cycle, treat it as a completed error, handled as in ERR.
- ERR: wait for hready_in = 1, then set ahb_resp_out = 1, leave data_out unchanged, pulse done_out, go to IDLE.
- Watchdog: only when TIMEOUT_CYCLES != 0. When the counter reaches TIMEOUT_CYCLES in DATA: set ahb_resp_out = 1, pulse done_out, go to IDLE. The counter clears on every entry to DATA.
- stall_out = 1 from the cycle after an accepted request up to and including the done_out cycle.
- Store lane replication:
  - byte: {4{rs2[7:0]}}, strobe 4'b0001 << addr[1:0].
  - half: {2{rs2[15:0]}}, strobe 4'b0011 << {addr[1], 1'b0}.
  - word: rs2, strobe 4'b1111.
- Load-unit outputs (iadder_1_to_0_out, load_size_out, load_unsigned_out) update at request acceptance and hold until the next acceptance.
- Latency with zero wait states: request at cycle N; address phase N+1; data phase N+2; done_out and data_out valid at N+3.
- A mem_req_in that arrives while busy is ignored; the pipeline must honour stall_out.

Decomposition:
- Shared package: HTRANS_IDLE/HTRANS_NONSEQ codes, size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), and the state enum.
- One sub-module, msrv32_store_align: combinational lane replication, strobe generation and misalignment check.

Test Plan:
- Load word at 0x1000, hrdata = 0xDEADBEEF, zero wait states -> done_out at N+3, data_out = 0xDEADBEEF, ahb_resp_out = 0, hsize_out = 010.
- Store byte 0xA5 at 0x2003 with 2 wait states -> hwdata_out = 0xA5A5A5A5, hwstrb_out = 1000, stall_out high for 5 cycles.
- Load half at 0x3001 -> misaligned_out pulses once, htrans_out stays 00, no done_out.
- ERROR response (hresp = 1 with hready = 0, then hresp = 1 with hready = 1) on a load -> ahb_resp_out = 1, data_out unchanged, done_out once.
- TIMEOUT_CYCLES = 4, hready held low -> abort after 4 data-phase cycles with ahb_resp_out = 1.
- rst_in asserted in DATA -> next cycle IDLE, stall_out = 0, htrans_out = 00, no done_out.
